idli_fetch_m: RTL and testbench

Instruction fetch buffer sitting directly downstream of the core's SQI read path. It collects the 4-bit read nibbles returned by the SQI controller, assembles every four into a 16-bit instruction word, and queues the words in a small FIFO. The FIFO presents instructions to decode over a valid/accept handshake. Backpressure goes back to the SQI sequencer as a stall request, and a flush input discards all buffered and partial words on a PC redirect.

---
 rtl/idli_fetch_m.sv | 171 +++++++++++++++++
 tb/tb_idli_fetch_m.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/idli_fetch_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_fetch_m
// Brief    : Instruction fetch buffer. Assembles 4-bit SQI read nibbles
//            (little-endian) into 16-bit instruction words and queues them
//            in a DEPTH-entry FIFO. Decode pops the head over a valid/accept
//            handshake. A registered stall request throttles the SQI
//            sequencer, and a flush discards everything on a PC redirect.
// Revision : 1.0 - initial release
// ============================================================================
module idli_fetch_m #(
    parameter int DEPTH = 2
) (
    input  logic                         i_fetch_gck,
    input  logic                         i_fetch_rst,
    input  logic [3:0]                   i_fetch_nib,
    input  logic                         i_fetch_nib_vld,
    input  logic                         i_fetch_flush,
    output logic                         o_fetch_stall,
    output logic [15:0]                  o_fetch_instr,
    output logic                         o_fetch_instr_vld,
    input  logic                         i_fetch_instr_acp,
    output logic [$clog2(DEPTH+1)-1:0]   o_fetch_count,
    output logic                         o_fetch_ovf
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [1:0]        c_LAST_IDX = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [15:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_idx;
    logic [11:0]        r_partial;
    logic               r_stall;
    logic               r_ovf;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic               w_vld;
    logic               w_pop;
    logic               w_room;
    logic               w_nib_acc;
    logic               w_nib_drop;
    logic               w_push;
    logic [c_CNT_W-1:0] w_count_next;
    logic [1:0]         w_idx_next;
    logic [c_CNT_W:0]   w_occupancy_next;
    logic               w_stall_next;

    assign w_vld = (r_count != '0);

    // A flush cycle ignores the accept entirely, so no pop can happen then.
    assign w_pop = w_vld & i_fetch_instr_acp & ~i_fetch_flush;

    // A word already in assembly owns its slot; a new word needs a free slot,
    // which may be the one vacated by a pop in this same cycle.
    assign w_room     = (r_idx != 2'd0) | (r_count < c_DEPTH) | w_pop;
    assign w_nib_acc  = i_fetch_nib_vld & ~i_fetch_flush & w_room;
    assign w_nib_drop = i_fetch_nib_vld & ~i_fetch_flush & ~w_room;
    assign w_push     = w_nib_acc & (r_idx == c_LAST_IDX);

    // Next word count: +1 on push, -1 on pop, cleared by flush.
    always_comb begin
        w_count_next = r_count;
        if (i_fetch_flush) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + c_CNT_W'(1);
                2'b01:   w_count_next = r_count - c_CNT_W'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Next nibble index: advances (and wraps) only on an accepted nibble.
    always_comb begin
        w_idx_next = r_idx;
        if (i_fetch_flush) begin
            w_idx_next = 2'd0;
        end else if (w_nib_acc) begin
            w_idx_next = r_idx + 2'd1;
        end
    end

    // Stall when complete words plus the reserved in-assembly slot fill the FIFO.
    assign w_occupancy_next = {1'b0, w_count_next} + (c_CNT_W + 1)'(w_idx_next != 2'd0);
    assign w_stall_next     = (w_occupancy_next >= {1'b0, c_DEPTH});

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Pointers, count, nibble index and stall register with reset/flush priority.
    always_ff @(posedge i_fetch_gck) begin
        if (i_fetch_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_idx   <= 2'd0;
            r_stall <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_idx   <= w_idx_next;
            r_stall <= w_stall_next;
            if (i_fetch_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_PTR_W'(1);
                end
            end
        end
    end

    // Partial word: lower three nibbles collected little-endian.
    always_ff @(posedge i_fetch_gck) begin
        if (i_fetch_rst || i_fetch_flush) begin
            r_partial <= 12'h000;
        end else if (w_nib_acc) begin
            case (r_idx)
                2'd0:    r_partial[3:0]  <= i_fetch_nib;
                2'd1:    r_partial[7:4]  <= i_fetch_nib;
                2'd2:    r_partial[11:8] <= i_fetch_nib;
                default: r_partial       <= 12'h000;
            endcase
        end
    end

    // Entry storage: the final nibble completes the word straight into the tail.
    always_ff @(posedge i_fetch_gck) begin
        if (w_push && !i_fetch_rst) begin
            r_mem[r_wptr] <= {i_fetch_nib, r_partial};
        end
    end

    // Sticky overflow: set on any nibble dropped for lack of space; flush keeps it.
    always_ff @(posedge i_fetch_gck) begin
        if (i_fetch_rst) begin
            r_ovf <= 1'b0;
        end else if (w_nib_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_fetch_instr_vld = w_vld;
    assign o_fetch_instr     = w_vld ? r_mem[r_rptr] : 16'h0000;
    assign o_fetch_count     = r_count;
    assign o_fetch_stall     = r_stall;
    assign o_fetch_ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_idli_fetch_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_idli_fetch_m
// Brief    : Self-checking bench for idli_fetch_m: directed vector table,
//            throughput run and randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idli_fetch_m;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    nib;
    logic          nib_vld;
    logic          flush;
    logic          stall;
    logic [15:0]   instr;
    logic          instr_vld;
    logic          acp;
    logic [CW-1:0] count;
    logic          ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    idli_fetch_m #(.DEPTH(DEPTH)) dut (
        .i_fetch_gck       (clk),
        .i_fetch_rst       (rst),
        .i_fetch_nib       (nib),
        .i_fetch_nib_vld   (nib_vld),
        .i_fetch_flush     (flush),
        .o_fetch_stall     (stall),
        .o_fetch_instr     (instr),
        .o_fetch_instr_vld (instr_vld),
        .i_fetch_instr_acp (acp),
        .o_fetch_count     (count),
        .o_fetch_ovf       (ovf)
    );

    // Reference model: a queue of complete words plus the nibbles of the
    // word being assembled.
    logic [15:0] mq[$];
    logic [3:0]  m_part[4];
    int          m_nn;
    bit          m_ovf;
    bit          m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit f, input bit nv,
                                input logic [3:0] n, input bit a);
        bit pop;
        bit take;
        if (r) begin
            mq.delete(); m_nn = 0; m_ovf = 0; m_stall = 0;
        end else if (f) begin
            mq.delete(); m_nn = 0; m_stall = 0;
        end else begin
            pop  = (mq.size() > 0) && a;
            take = nv && (m_nn != 0 || mq.size() < DEPTH || pop);
            if (nv && !take) m_ovf = 1;
            if (pop) void'(mq.pop_front());
            if (take) begin
                m_part[m_nn] = n;
                m_nn++;
                if (m_nn == 4) begin
                    mq.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
                    m_nn = 0;
                end
            end
            m_stall = (mq.size() + ((m_nn != 0) ? 1 : 0)) >= DEPTH;
        end
    endtask

    task automatic check_model();
        bit v;
        v = mq.size() > 0;
        chk("model_vld",   32'(instr_vld), 32'(v));
        chk("model_instr", 32'(instr),     v ? 32'(mq[0]) : 32'h0);
        chk("model_count", 32'(count),     32'(mq.size()));
        chk("model_stall", 32'(stall),     32'(m_stall));
        chk("model_ovf",   32'(ovf),       32'(m_ovf));
    endtask

    // Apply one cycle of inputs, advance the model, then sample after the edge.
    task automatic step(input bit r, input bit f, input bit nv,
                        input logic [3:0] n, input bit a);
        rst = r; flush = f; nib_vld = nv; nib = n; acp = a;
        model_update(r, f, nv, n, a);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit          rst;
        bit          flush;
        bit          nv;
        logic [3:0]  nib;
        bit          acp;
        bit          e_vld;
        logic [15:0] e_instr;
        int          e_cnt;
        bit          e_stall;
        bit          e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input bit r, input bit f, input bit nv, input logic [3:0] n, input bit a,
                     input bit ev, input logic [15:0] ei, input int ec, input bit es, input bit eo);
        vec_t x;
        x.rst = r; x.flush = f; x.nv = nv; x.nib = n; x.acp = a;
        x.e_vld = ev; x.e_instr = ei; x.e_cnt = ec; x.e_stall = es; x.e_ovf = eo;
        tbl.push_back(x);
    endtask

    logic [15:0] words[10];
    logic [15:0] seen[$];

    initial begin
        rst = 1'b1; flush = 1'b0; nib_vld = 1'b0; nib = 4'h0; acp = 1'b0;

        // ---- directed table: rst flush nv nib acp | vld instr cnt stall ovf
        v(1,0,0,4'h0,0, 0,16'h0000,0,0,0);
        // single word 4,3,2,1 -> 1234, then pop it
        v(0,0,1,4'h4,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'h3,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'h2,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'h1,0, 1,16'h1234,1,0,0);
        v(0,0,0,4'h0,1, 0,16'h0000,0,0,0);
        // fill A5A5 then 5A5A, stall after first nibble of word 2
        v(0,0,1,4'h5,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'hA,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'h5,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'hA,0, 1,16'hA5A5,1,0,0);
        v(0,0,1,4'hA,0, 1,16'hA5A5,1,1,0);
        v(0,0,1,4'h5,0, 1,16'hA5A5,1,1,0);
        v(0,0,1,4'hA,0, 1,16'hA5A5,1,1,0);
        v(0,0,1,4'h5,0, 1,16'hA5A5,2,1,0);
        // 9th nibble dropped
        v(0,0,1,4'h7,0, 1,16'hA5A5,2,1,1);
        // drain, stall falls after first pop
        v(0,0,0,4'h0,1, 1,16'h5A5A,1,0,1);
        v(0,0,0,4'h0,1, 0,16'h0000,0,0,1);
        // full-FIFO swap
        v(1,0,0,4'h0,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'h1,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'h1,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'h1,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'h1,0, 1,16'h1111,1,0,0);
        v(0,0,1,4'h2,0, 1,16'h1111,1,1,0);
        v(0,0,1,4'h2,0, 1,16'h1111,1,1,0);
        v(0,0,1,4'h2,0, 1,16'h1111,1,1,0);
        v(0,0,1,4'h2,0, 1,16'h1111,2,1,0);
        v(0,0,1,4'h3,1, 1,16'h2222,1,1,0);
        v(0,0,1,4'h3,0, 1,16'h2222,1,1,0);
        v(0,0,1,4'h3,0, 1,16'h2222,1,1,0);
        v(0,0,1,4'h3,0, 1,16'h2222,2,1,0);
        // flush with two words buffered and a nibble/accept presented
        v(0,1,1,4'h9,1, 0,16'h0000,0,0,0);
        v(0,0,1,4'hF,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'hE,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'hE,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'hB,0, 1,16'hBEEF,1,0,0);
        // flush mid-word (idx = 2), then a clean word
        v(0,0,1,4'h1,0, 1,16'hBEEF,1,1,0);
        v(0,0,1,4'h2,0, 1,16'hBEEF,1,1,0);
        v(0,1,0,4'h0,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'hD,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'hA,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'hE,0, 0,16'h0000,0,0,0);
        v(0,0,1,4'hD,0, 1,16'hDEAD,1,0,0);
        // build: 1 word buffered, idx = 3, ovf = 1, then reset
        v(0,0,1,4'h1,0, 1,16'hDEAD,1,1,0);
        v(0,0,1,4'h1,0, 1,16'hDEAD,1,1,0);
        v(0,0,1,4'h1,0, 1,16'hDEAD,1,1,0);
        v(0,0,1,4'h1,0, 1,16'hDEAD,2,1,0);
        v(0,0,1,4'h5,0, 1,16'hDEAD,2,1,1);
        v(0,0,0,4'h0,1, 1,16'h1111,1,0,1);
        v(0,0,1,4'h6,0, 1,16'h1111,1,1,1);
        v(0,0,1,4'h6,0, 1,16'h1111,1,1,1);
        v(0,0,1,4'h6,0, 1,16'h1111,1,1,1);
        v(1,0,1,4'h6,1, 0,16'h0000,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].nv, tbl[i].nib, tbl[i].acp);
            chk($sformatf("tbl%0d_vld", i),   32'(instr_vld), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_instr", i), 32'(instr),     32'(tbl[i].e_instr));
            chk($sformatf("tbl%0d_count", i), 32'(count),     32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_stall", i), 32'(stall),     32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_ovf", i),   32'(ovf),       32'(tbl[i].e_ovf));
        end

        // ---- throughput: continuous stream with accept held high
        step(1, 0, 0, 4'h0, 0);
        for (int k = 0; k < 10; k++) words[k] = 16'($urandom);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                step(0, 0, 1, words[k][4*j +: 4], 1);
                chk("thru_stall", 32'(stall), 32'h0);
                if (instr_vld) seen.push_back(instr);
            end
        end
        chk("thru_words", 32'(seen.size()), 32'd10);
        for (int k = 0; k < 10 && k < seen.size(); k++)
            chk($sformatf("thru_word%0d", k), 32'(seen[k]), 32'(words[k]));

        // ---- randomized traffic against the model
        step(1, 0, 0, 4'h0, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 7),
                 4'($urandom),
                 ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
